// File: rtl/rx_udp_pkg.sv
// Shared definitions for the receive-path UDP stage.
package rx_udp_pkg;

  // Parser state encodings (kept as plain constants for legacy compatibility)
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SRC_PORT = 3'd1;
  localparam logic [2:0] S_DST_PORT = 3'd2;
  localparam logic [2:0] S_LEN      = 3'd3;
  localparam logic [2:0] S_CSUM     = 3'd4;
  localparam logic [2:0] S_DATA     = 3'd5;
  localparam logic [2:0] S_DROP     = 3'd6;

  // UDP header size in bytes
  localparam int unsigned UDP_HDR_LEN = 8;

  // IPv4 protocol number for UDP, shared with the IPv4 stage
  localparam logic [7:0] UDP_PROTOCOL = 8'h11;

endpackage

// File: rtl/rx_udp.sv
// Receive-path UDP stage: parses the 8-byte UDP header from the IPv4 payload
// stream, filters on protocol/destination port/length, and forwards the
// payload trimmed to the UDP length with a one-cycle latency.
module rx_udp
  import rx_udp_pkg::*;
#(
  parameter int unsigned    OCT = 8,
  parameter logic [OCT-1:0] UDP = OCT'(UDP_PROTOCOL)
) (
  input  logic             RX_CLK,
  input  logic             rst,
  input  logic             func_en,
  input  logic [2*OCT-1:0] udp_port,
  input  logic [OCT-1:0]   rx_protocol,
  input  logic             rx_ipv4_irq,
  input  logic             rx_ipv4_data_v,
  input  logic [OCT-1:0]   rx_ipv4_data,
  output logic [2*OCT-1:0] rx_src_port,
  output logic [2*OCT-1:0] rx_dst_port,
  output logic [2*OCT-1:0] rx_udp_len,
  output logic [2*OCT-1:0] rx_udp_checksum,
  output logic             rx_udp_irq,
  output logic             rx_udp_data_v,
  output logic [OCT-1:0]   rx_udp_data,
  output logic             rx_udp_last,
  output logic             rx_udp_err
);

  localparam int unsigned W = 2 * OCT;

  logic [2:0]     r_state;
  logic           r_cnt;
  logic [W-1:0]   r_remain;
  logic           r_prev_v;
  logic           r_arm;
  logic [W-1:0]   r_src;
  logic [W-1:0]   r_dst;
  logic [W-1:0]   r_len;
  logic [W-1:0]   r_csum;
  logic           r_irq;
  logic           r_data_v;
  logic [OCT-1:0] r_data;
  logic           r_last;
  logic           r_err;

  logic [2:0]     w_state_nxt;
  logic           w_sof;
  logic           w_accept;
  logic           w_has_payload;

  // Start-of-frame and acceptance qualifiers.
  // r_arm is cleared by reset and set once valid has been seen low, so a frame
  // that was already in flight when reset hit is ignored until a fresh edge.
  always_comb begin
    w_sof         = r_arm & ~r_prev_v & rx_ipv4_data_v;
    w_accept      = (rx_protocol == UDP) && (r_dst == udp_port) &&
                    (r_len >= W'(UDP_HDR_LEN));
    w_has_payload = (r_len != W'(UDP_HDR_LEN));
  end

  // Next-state decode; the state only advances while the block is enabled.
  always_comb begin
    w_state_nxt = r_state;
    if (func_en) begin
      case (r_state)
        S_IDLE:     if (w_sof) w_state_nxt = S_SRC_PORT;
        S_SRC_PORT: w_state_nxt = rx_ipv4_data_v ? S_DST_PORT : S_IDLE;
        S_DST_PORT: begin
          if (!rx_ipv4_data_v) w_state_nxt = S_IDLE;
          else if (r_cnt)      w_state_nxt = S_LEN;
        end
        S_LEN: begin
          if (!rx_ipv4_data_v) w_state_nxt = S_IDLE;
          else if (r_cnt)      w_state_nxt = S_CSUM;
        end
        S_CSUM: begin
          if (!rx_ipv4_data_v) w_state_nxt = S_IDLE;
          else if (r_cnt)      w_state_nxt = (w_accept && w_has_payload) ? S_DATA : S_DROP;
        end
        S_DATA: begin
          if (!rx_ipv4_data_v)           w_state_nxt = S_IDLE;
          else if (r_remain == W'(1))    w_state_nxt = S_DROP;
        end
        S_DROP:     if (!rx_ipv4_data_v) w_state_nxt = S_IDLE;
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, header capture, payload forwarding and status pulses.
  // The first source-port byte is captured while still in IDLE, so SRC_PORT
  // only needs to take the low byte.
  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 1'b0;
      r_remain <= '0;
      r_prev_v <= 1'b0;
      r_arm    <= 1'b0;
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_csum   <= '0;
      r_irq    <= 1'b0;
      r_data_v <= 1'b0;
      r_data   <= '0;
      r_last   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_irq    <= rx_ipv4_irq;
      r_data_v <= 1'b0;
      r_last   <= 1'b0;
      r_err    <= 1'b0;
      if (func_en) begin
        r_state  <= w_state_nxt;
        r_prev_v <= rx_ipv4_data_v;
        if (!rx_ipv4_data_v) r_arm <= 1'b1;

        if (w_state_nxt != r_state) r_cnt <= 1'b0;
        else if (rx_ipv4_data_v)    r_cnt <= 1'b1;

        case (r_state)
          S_IDLE: begin
            if (w_sof) begin
              r_src[W-1:OCT] <= rx_ipv4_data;
              r_src[OCT-1:0] <= '0;
            end
          end
          S_SRC_PORT: if (rx_ipv4_data_v) r_src[OCT-1:0] <= rx_ipv4_data;
          S_DST_PORT: if (rx_ipv4_data_v) r_dst <= {r_dst[OCT-1:0], rx_ipv4_data};
          S_LEN:      if (rx_ipv4_data_v) r_len <= {r_len[OCT-1:0], rx_ipv4_data};
          S_CSUM: begin
            if (rx_ipv4_data_v) begin
              r_csum <= {r_csum[OCT-1:0], rx_ipv4_data};
              if (r_cnt) r_remain <= r_len - W'(UDP_HDR_LEN);
            end
          end
          S_DATA: begin
            if (!rx_ipv4_data_v) begin
              r_err <= 1'b1;
            end else begin
              r_data_v <= 1'b1;
              r_data   <= rx_ipv4_data;
              r_remain <= r_remain - W'(1);
              if (r_remain == W'(1)) r_last <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_src_port     = r_src;
  assign rx_dst_port     = r_dst;
  assign rx_udp_len      = r_len;
  assign rx_udp_checksum = r_csum;
  assign rx_udp_irq      = r_irq;
  assign rx_udp_data_v   = r_data_v;
  assign rx_udp_data     = r_data;
  assign rx_udp_last     = r_last;
  assign rx_udp_err      = r_err;

endmodule
